// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-port round-robin arbiter and access sequencer for a 2**AW x DW
//   single-port RAM with a level-sensitive write. Each granted access runs
//   SETUP -> STROBE -> HOLD, so address and data are stable for one cycle
//   before and one cycle after the single-cycle write strobe.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mN_req/we/addr/wdata     port N request (held until mN_ack), fields stable while req
//   mN_ack                   port N one-cycle completion pulse (HOLD state)
//   mN_rdata                 port N registered read data, held until its next read
//   ram_cs/ram_wr            registered RAM chip select / write enable
//   ram_addr/ram_din         RAM address / write data, change only on entry to SETUP
//   ram_dout                 RAM read data
//   busy                     high in every non-IDLE state
module ram_arbiter #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          ram_cs,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;          // port granted most recently
   logic            cur_port_q, cur_port_d;
   logic            cur_we_q, cur_we_d;
   logic [AW-1:0]   cur_addr_q, cur_addr_d;
   logic [DW-1:0]   cur_wdata_q, cur_wdata_d;
   logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
   logic            ram_cs_q, ram_cs_d;
   logic            ram_wr_q, ram_wr_d;

   logic            grant_valid;
   logic            grant_port;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;                // port 0 wins the first contention
         cur_port_q  <= 1'b0;
         cur_we_q    <= 1'b0;
         cur_addr_q  <= '0;
         cur_wdata_q <= '0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         ram_cs_q    <= 1'b0;
         ram_wr_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         last_q      <= last_d;
         cur_port_q  <= cur_port_d;
         cur_we_q    <= cur_we_d;
         cur_addr_q  <= cur_addr_d;
         cur_wdata_q <= cur_wdata_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         ram_cs_q    <= ram_cs_d;
         ram_wr_q    <= ram_wr_d;
      end
   end

   // Next-state, arbitration and request latching
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d     = state_q;
      last_d      = last_q;
      cur_port_d  = cur_port_q;
      cur_we_d    = cur_we_q;
      cur_addr_d  = cur_addr_q;
      cur_wdata_d = cur_wdata_q;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
      grant_valid = 1'b0;
      grant_port  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               grant_valid = 1'b1;
               // Contention goes to the port that was not granted last.
               grant_port  = (m0_req && m1_req) ? ~last_q : m1_req;
            end
         end
         SETUP: state_d = STROBE;
         STROBE: begin
            state_d = HOLD;
            if (!cur_we_q) begin
               if (cur_port_q) m1_rdata_d = ram_dout;
               else            m0_rdata_d = ram_dout;
            end
         end
         HOLD: begin
            state_d = IDLE;
            // The current port's req is still high here, so only the other
            // port is eligible for a back-to-back grant.
            if (cur_port_q ? m0_req : m1_req) begin
               grant_valid = 1'b1;
               grant_port  = ~cur_port_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_valid) begin
         state_d     = SETUP;
         last_d      = grant_port;
         cur_port_d  = grant_port;
         cur_we_d    = grant_port ? m1_we    : m0_we;
         cur_addr_d  = grant_port ? m1_addr  : m0_addr;
         cur_wdata_d = grant_port ? m1_wdata : m0_wdata;
      end
   end

   // Outputs: RAM strobes are computed from the next state and registered,
   // acks and busy decode the current state.
   always_comb begin
      ram_cs_d = (state_d != IDLE);
      ram_wr_d = (state_d == STROBE) && cur_we_q;
      m0_ack   = (state_q == HOLD) && !cur_port_q;
      m1_ack   = (state_q == HOLD) &&  cur_port_q;
      busy     = (state_q != IDLE);
   end

   assign ram_cs   = ram_cs_q;
   assign ram_wr   = ram_wr_q;
   assign ram_addr = cur_addr_q;
   assign ram_din  = cur_wdata_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and access sequencer for the 1024 x 8 single-port RAM. Two requesters issue single-byte read or write requests over a req/ack handshake. The arbiter grants one request at a time and drives the RAM's chip-select, write-enable, address and data through a SETUP/STROBE/HOLD sequence, so the RAM's level-sensitive write never sees address or data change while write-enable is high. Read data is registered per port. It sits between the RAM and its clients, which must never drive the RAM directly.

## Interface
- AW, 10: address width (RAM depth 2**AW).
- DW, 8: data width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held high until m0_ack.
- m0_we  in  1  port 0: 1 = write, 0 = read; stable while m0_req is high.
- m0_addr  in  AW  port 0 address; stable while m0_req is high.
- m0_wdata  in  DW  port 0 write data; stable while m0_req is high.
- m0_ack  out  1  port 0 one-cycle completion pulse.
- m0_rdata  out  DW  port 0 read data; valid from the m0_ack cycle, held until that port's next read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same meanings as the m0_* ports, for port 1.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; high-Z when the RAM is not reading.
- busy  out  1  high in every non-IDLE state.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD.
- **Reset value of every output:** all outputs 0, including m0_rdata and m1_rdata. Internal reset values: state = IDLE, last-grant pointer = 1, so port 0 wins the first contention.
- **IDLE:**
  - If any req is high, grant one port and latch its we, addr and wdata into internal registers (cur_port, cur_we, cur_addr, cur_wdata), then go to SETUP.
  - If both ports request, grant the port that is not the last-grant pointer.
  - On every grant, last-grant pointer := granted port.
- **SETUP:** ram_cs = 1, ram_wr = 0, ram_addr = cur_addr, ram_din = cur_wdata. Go to STROBE.
- **STROBE:**
  - ram_cs = 1, ram_wr = cur_we, address and data unchanged.
  - Read: capture ram_dout into the rdata register of cur_port at the edge leaving STROBE.
  - Go to HOLD.
- **HOLD:**
  - ram_cs = 1, ram_wr = 0, address and data unchanged. mN_ack = 1 for cur_port only.
  - Arbitration considers only the other port, because the current port's req is still high this cycle.
  - If the other port requests, latch its fields and go to SETUP (a back-to-back grant).
  - Otherwise go to IDLE.
- **ram_cs/ram_wr drive:** both are registered outputs, so there are no combinational glitches. ram_addr and ram_din change only on entry to SETUP.
- **RAM port in IDLE:** ram_cs = 0 and ram_wr = 0. ram_addr and ram_din hold their last values.
- **Requester protocol:**
  - A requester may drop req in the cycle after it sees ack, or keep it high to issue a new request.
  - If req is still high in the cycle after ack, that is a new request. It is arbitrated normally: it wins IDLE arbitration if uncontested, and loses to the other port if contested.
  - Changing we, addr or wdata while req is high and before ack is illegal; the result is undefined but the arbiter must not hang.
- **Fairness:** under continuous requests from both ports, grants strictly alternate 0, 1, 0, 1.

## Timing
- **Latency:** req sampled high in IDLE at edge E; SETUP in cycle E+1, STROBE in E+2, ack in E+3 (HOLD).
- **Read data:** rdata is valid in the ack cycle.
- **Throughput:** back-to-back grants complete one access every 3 cycles. A lone requester that re-requests passes through IDLE, giving 4 cycles per access.
- **Write strobe:** ram_wr is high for exactly one cycle, with one cycle of stable address and data before it (SETUP) and one after it (HOLD).
- **Simultaneous requests in IDLE:** round-robin decides; the losing port waits and is granted from HOLD.
- **Reset mid-operation:** all outputs go to 0 immediately (asynchronous) and no ack is issued. RAM contents at cur_addr are undefined if reset hits STROBE during a write. Requesters must reissue after reset.
- **Address extremes:** addresses 0 and 2**AW-1 need no special handling; there is no wrap or increment logic.

## Test plan
- **Single write then read, port 0:** write 0xA5 to addr 0x3FF, then read addr 0x3FF.
  - Write: ram_wr high exactly one cycle, ack at E+3.
  - Read: m0_rdata = 0xA5 at ack, m1_ack never pulses.
- **Contention from reset:** both ports read at the same edge (m0 addr 0x001, m1 addr 0x002, preloaded with 0x11/0x22).
  - Port 0 acks first with 0x11; port 1 acks 3 cycles later with 0x22.
  - busy stays high throughout.
- **Sustained contention:** both ports hold req for 8 accesses each.
  - Grants alternate 0, 1, 0, 1 with an ack every 3 cycles.
  - No port is acked twice in a row.
- **Strobe discipline:** on every write, ram_addr and ram_din are checked constant whenever ram_wr = 1 and on the cycles immediately before and after; ram_cs = 1 across SETUP..HOLD.
- **Reset in STROBE:** assert rst during a write's STROBE cycle.
  - ram_cs, ram_wr, ack and busy go to 0 without waiting for a clock edge.
  - After release, a new port 1 request is served with normal latency.
- **rdata hold:** port 1 reads 0x7E, then port 1 writes 0x00 to the same address. m1_rdata stays 0x7E until the next port 1 read completes.
